// File: rtl/enigma_key_sequencer.sv
// Keystroke front end for the Enigma datapath: classifies ASCII input, applies the
// plugboard on entry and exit, steps the rotor stack and emits ASCII ciphertext.
module enigma_key_sequencer #(
    parameter bit LOWERCASE_OUT = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_char,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_char,
    input  logic       plug_wr,
    input  logic       plug_clr,
    input  logic [4:0] plug_a,
    input  logic [4:0] plug_b,
    output logic       new_char,
    output logic [4:0] to_rotor,
    input  logic [4:0] from_rotor,
    output logic       busy,
    output logic [15:0] char_count
);

    localparam int unsigned NUM_LETTERS = 26;
    localparam int unsigned IDX_W       = 5;
    localparam int unsigned CHAR_W      = 8;
    localparam int unsigned CNT_W       = 16;
    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_LETTERS - 1);
    localparam logic [CHAR_W-1:0] FAULT_CHAR = 8'h3F;
    localparam logic [CHAR_W-1:0] OUT_BASE   = LOWERCASE_OUT ? 8'h61 : 8'h41;

    typedef enum logic [1:0] {IDLE, STEP, SETTLE, OUT} state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    plug_q [NUM_LETTERS];
    logic [IDX_W-1:0]    plug_d [NUM_LETTERS];
    logic [IDX_W-1:0]    to_rotor_q, to_rotor_d;
    logic [CHAR_W-1:0]   out_char_q, out_char_d;
    logic [CNT_W-1:0]    char_count_q, char_count_d;
    logic                out_valid_q, out_valid_d;
    logic                new_char_q, new_char_d;
    logic                busy_q, busy_d;

    logic                is_upper, is_lower, accept;
    logic [IDX_W-1:0]    key_idx;
    logic [IDX_W-1:0]    plug_key, plug_ret, partner_a, partner_b;
    logic                plug_ops_ok;

    // Keystroke classification and letter index.
    always_comb begin
        is_upper = (in_char >= 8'h41) && (in_char <= 8'h5A);
        is_lower = (in_char >= 8'h61) && (in_char <= 8'h7A);
        key_idx  = is_upper ? IDX_W'(in_char - 8'h41) : IDX_W'(in_char - 8'h61);
        in_ready = (state_q == IDLE) && !plug_wr && !plug_clr;
        accept   = in_valid && in_ready && (is_upper || is_lower);
    end

    // Table lookups as explicit muxes so out-of-range indices read as zero.
    always_comb begin
        plug_key  = '0;
        plug_ret  = '0;
        partner_a = '0;
        partner_b = '0;
        for (int unsigned i = 0; i < NUM_LETTERS; i++) begin
            if (IDX_W'(i) == key_idx)    plug_key  = plug_q[i];
            if (IDX_W'(i) == from_rotor) plug_ret  = plug_q[i];
            if (IDX_W'(i) == plug_a)     partner_a = plug_q[i];
            if (IDX_W'(i) == plug_b)     partner_b = plug_q[i];
        end
    end

    // Plugboard update: unpair old partners first so the table stays an involution.
    always_comb begin
        plug_ops_ok = (plug_a <= LAST_IDX) && (plug_b <= LAST_IDX);
        for (int unsigned i = 0; i < NUM_LETTERS; i++) plug_d[i] = plug_q[i];
        if (state_q == IDLE) begin
            if (plug_clr) begin
                for (int unsigned i = 0; i < NUM_LETTERS; i++) plug_d[i] = IDX_W'(i);
            end else if (plug_wr && plug_ops_ok) begin
                for (int unsigned i = 0; i < NUM_LETTERS; i++) begin
                    if ((IDX_W'(i) == partner_a) || (IDX_W'(i) == partner_b)) plug_d[i] = IDX_W'(i);
                end
                for (int unsigned i = 0; i < NUM_LETTERS; i++) begin
                    if (IDX_W'(i) == plug_a)      plug_d[i] = plug_b;
                    else if (IDX_W'(i) == plug_b) plug_d[i] = plug_a;
                end
            end
        end
    end

    // Sequencer next state and registered outputs.
    always_comb begin
        state_d      = state_q;
        to_rotor_d   = to_rotor_q;
        out_char_d   = out_char_q;
        out_valid_d  = out_valid_q;
        char_count_d = char_count_q;
        new_char_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d    = STEP;
                    new_char_d = 1'b1;
                    to_rotor_d = plug_key;
                end
            end
            STEP: begin
                state_d      = SETTLE;
                char_count_d = char_count_q + 16'd1;
            end
            SETTLE: begin
                state_d     = OUT;
                out_valid_d = 1'b1;
                out_char_d  = (from_rotor <= LAST_IDX) ? (OUT_BASE + CHAR_W'(plug_ret)) : FAULT_CHAR;
            end
            OUT: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            to_rotor_q   <= '0;
            out_char_q   <= '0;
            out_valid_q  <= 1'b0;
            char_count_q <= '0;
            new_char_q   <= 1'b0;
            busy_q       <= 1'b0;
            for (int unsigned i = 0; i < NUM_LETTERS; i++) plug_q[i] <= IDX_W'(i);
        end else begin
            state_q      <= state_d;
            to_rotor_q   <= to_rotor_d;
            out_char_q   <= out_char_d;
            out_valid_q  <= out_valid_d;
            char_count_q <= char_count_d;
            new_char_q   <= new_char_d;
            busy_q       <= busy_d;
            for (int unsigned i = 0; i < NUM_LETTERS; i++) plug_q[i] <= plug_d[i];
        end
    end

    assign to_rotor   = to_rotor_q;
    assign out_char   = out_char_q;
    assign out_valid  = out_valid_q;
    assign char_count = char_count_q;
    assign new_char   = new_char_q;
    assign busy       = busy_q;

endmodule
